// File: rtl/sq_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sq_period_meter: measures the rising-edge period of an async square wave  |
// | in clk cycles; optional high-time counter under SQ_PERIOD_METER_HIGH_EN.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sq_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sq_in,
  input  logic             clr_timeout,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
`ifdef SQ_PERIOD_METER_HIGH_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             timeout
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_d;
  logic                   rise_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       period_q;
  logic                   valid_q;
  logic                   locked_q;
  logic                   timeout_q;

  assign rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sq_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= rise_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Clear first so a coincident saturation below overrides it.
      if (clr_timeout) begin
        timeout_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          locked_q <= 1'b0;
          cnt_q    <= '0;
          if (rise_q) begin
            cnt_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_q  <= MEASURE;
            locked_q <= 1'b1;
          end
        end
        MEASURE: begin
          locked_q <= 1'b1;
          if (rise_q) begin
            period_q <= cnt_q;
            valid_q  <= 1'b1;
            cnt_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (cnt_q == c_cnt_max) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
            locked_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

`ifdef SQ_PERIOD_METER_HIGH_EN
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_time_q;

  // hist_q is the synchronised level aligned with rise_q, so it marks the
  // same cycles the FSM sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cnt_q  <= '0;
      high_time_q <= '0;
    end else begin
      if (rise_q) begin
        if (state_q == MEASURE) begin
          high_time_q <= high_cnt_q;
        end
        high_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (state_q == MEASURE) begin
        if (cnt_q == c_cnt_max) begin
          high_cnt_q <= '0;
        end else if (hist_q && (high_cnt_q != c_cnt_max)) begin
          high_cnt_q <= high_cnt_q + 1'b1;
        end
      end else begin
        high_cnt_q <= '0;
      end
    end
  end

  assign high_time = high_time_q;
`endif

endmodule
`default_nettype wire
